// File: rtl/lcd_hd44780_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lcd_hd44780_responder                                                    |
// | HD44780-compatible LCD pin responder: DDRAM/CGRAM, AC, timed busy flag.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lcd_hd44780_responder #(
    parameter int EXEC_CYCLES  = 1850,
    parameter int CLEAR_CYCLES = 76000,
    parameter int BUSY_W       = 17
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        LCD_E,
    input  logic        LCD_RS,
    input  logic        LCD_RW,
    inout  wire  [7:0]  LCD_data,
    input  logic [6:0]  dbg_addr,
    output logic [7:0]  dbg_char,
    output logic        disp_on,
    output logic        cursor_on,
    output logic        blink_on,
    output logic        err
);

    localparam int              DDRAM_BYTES = 80;
    localparam int              CGRAM_BYTES = 64;
    localparam logic [7:0]      BLANK       = 8'h20;
    localparam logic [6:0]      FILL_LAST   = 7'(DDRAM_BYTES - 1);
    localparam logic [BUSY_W-1:0] EXEC_LOAD  = BUSY_W'(EXEC_CYCLES - 1);
    localparam logic [BUSY_W-1:0] HOME_LOAD  = BUSY_W'(CLEAR_CYCLES - 1);
    localparam logic [BUSY_W-1:0] CLEAR_TAIL = BUSY_W'(CLEAR_CYCLES - DDRAM_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY     = 2'd1,
        CLEARING = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [BUSY_W-1:0] busy_cnt;
    logic [BUSY_W-1:0] next_cnt;
    logic [6:0]        fill_idx;
    logic [6:0]        next_fill;

    logic [7:0] ddram [0:DDRAM_BYTES-1];
    logic [7:0] cgram [0:CGRAM_BYTES-1];

    logic [1:0] e_sync;
    logic [1:0] rs_sync;
    logic [1:0] rw_sync;
    logic [7:0] d_meta;
    logic [7:0] d_sync;
    logic       e_prev;
    logic       rs_prev;
    logic       rw_prev;
    logic [7:0] d_prev;

    logic [6:0] ac;
    logic       to_cgram;
    logic       inc;
    logic       entry_s;
    logic       func_dl;
    logic       func_n;
    logic       func_f;
    logic [7:0] rd_data;
    logic [7:0] ac_byte;

    logic bf;
    logic e_fall;
    logic is_write;
    logic is_data_read;
    logic blocked;
    logic inst_wr;
    logic data_wr;
    logic data_rd;
    logic is_clear;
    logic is_home;

    function automatic logic ddram_valid(input logic [6:0] a);
        return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
    endfunction

    function automatic logic [6:0] ddram_index(input logic [6:0] a);
        return a[6] ? ({1'b0, a[5:0]} + 7'd40) : {1'b0, a[5:0]};
    endfunction

    // Line-to-line wrap keeps AC inside the visible 2x40 address window.
    function automatic logic [6:0] step_ac(input logic [6:0] a, input logic cg, input logic up);
        if (cg) begin
            return {1'b0, (up ? (a[5:0] + 6'd1) : (a[5:0] - 6'd1))};
        end
        if (up) begin
            if (a == 7'h27) return 7'h40;
            if (a == 7'h67) return 7'h00;
            return a + 7'd1;
        end
        if (a == 7'h00) return 7'h67;
        if (a == 7'h40) return 7'h27;
        return a - 7'd1;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_sync  <= 2'b00;
            rs_sync <= 2'b00;
            rw_sync <= 2'b00;
            d_meta  <= 8'h00;
            d_sync  <= 8'h00;
            e_prev  <= 1'b0;
            rs_prev <= 1'b0;
            rw_prev <= 1'b0;
            d_prev  <= 8'h00;
        end else begin
            e_sync  <= {e_sync[0], LCD_E};
            rs_sync <= {rs_sync[0], LCD_RS};
            rw_sync <= {rw_sync[0], LCD_RW};
            d_meta  <= LCD_data;
            d_sync  <= d_meta;
            e_prev  <= e_sync[1];
            rs_prev <= rs_sync[1];
            rw_prev <= rw_sync[1];
            d_prev  <= d_sync;
        end
    end

    // Control/data are taken from the stage that still saw E high.
    assign e_fall       = e_prev & ~e_sync[1];
    assign bf           = (state != IDLE);
    assign is_write     = e_fall & ~rw_prev;
    assign is_data_read = e_fall & rw_prev & rs_prev;
    assign blocked      = bf & (is_write | is_data_read);
    assign inst_wr      = ~bf & is_write & ~rs_prev;
    assign data_wr      = ~bf & is_write & rs_prev;
    assign data_rd      = ~bf & is_data_read;
    assign is_clear     = inst_wr & (d_prev == 8'h01);
    assign is_home      = inst_wr & (d_prev[7:1] == 7'b0000001);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            busy_cnt <= '0;
            fill_idx <= 7'd0;
        end else begin
            state    <= next_state;
            busy_cnt <= next_cnt;
            fill_idx <= next_fill;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = busy_cnt;
        next_fill  = fill_idx;
        case (state)
            IDLE: begin
                if (is_clear) begin
                    next_state = CLEARING;
                    next_fill  = 7'd0;
                end else if (is_home) begin
                    next_state = BUSY;
                    next_cnt   = HOME_LOAD;
                end else if (inst_wr || data_wr) begin
                    next_state = BUSY;
                    next_cnt   = EXEC_LOAD;
                end
            end
            CLEARING: begin
                // The fill cycles count toward the clear busy time.
                if (fill_idx == FILL_LAST) begin
                    if (CLEAR_CYCLES > DDRAM_BYTES) begin
                        next_state = BUSY;
                        next_cnt   = CLEAR_TAIL;
                    end else begin
                        next_state = IDLE;
                    end
                end else begin
                    next_fill = fill_idx + 7'd1;
                end
            end
            BUSY: begin
                if (busy_cnt == '0) begin
                    next_state = IDLE;
                end else begin
                    next_cnt = busy_cnt - 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ac        <= 7'd0;
            to_cgram  <= 1'b0;
            inc       <= 1'b1;
            entry_s   <= 1'b0;
            disp_on   <= 1'b0;
            cursor_on <= 1'b0;
            blink_on  <= 1'b0;
            func_dl   <= 1'b1;
            func_n    <= 1'b1;
            func_f    <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (blocked) begin
                err <= 1'b1;
            end
            if (inst_wr) begin
                casez (d_prev)
                    8'b1???????: begin
                        ac       <= d_prev[6:0];
                        to_cgram <= 1'b0;
                    end
                    8'b01??????: begin
                        ac       <= {1'b0, d_prev[5:0]};
                        to_cgram <= 1'b1;
                    end
                    8'b001?????: {func_dl, func_n, func_f} <= d_prev[4:2];
                    8'b0001????: begin
                        if (!d_prev[3]) begin
                            ac <= step_ac(ac, to_cgram, d_prev[2]);
                        end
                    end
                    8'b00001???: {disp_on, cursor_on, blink_on} <= d_prev[2:0];
                    8'b000001??: begin
                        inc     <= d_prev[1];
                        entry_s <= d_prev[0];
                    end
                    8'b0000001?: ac <= 7'd0;
                    8'b00000001: begin
                        ac  <= 7'd0;
                        inc <= 1'b1;
                    end
                    default: ;
                endcase
            end else if (data_wr || data_rd) begin
                ac <= step_ac(ac, to_cgram, inc);
            end
        end
    end

    // RAM contents survive reset; only the fill sequencer is reset.
    always_ff @(posedge clk) begin
        if (state == CLEARING) begin
            ddram[fill_idx] <= BLANK;
        end else if (data_wr && !to_cgram && ddram_valid(ac)) begin
            ddram[ddram_index(ac)] <= d_prev;
        end
        if (data_wr && to_cgram) begin
            cgram[ac[5:0]] <= d_prev;
        end
    end

    always_comb begin
        ac_byte = BLANK;
        if (to_cgram) begin
            ac_byte = cgram[ac[5:0]];
        end else if (ddram_valid(ac)) begin
            ac_byte = ddram[ddram_index(ac)];
        end
    end

    always_comb begin
        dbg_char = BLANK;
        if (ddram_valid(dbg_addr)) begin
            dbg_char = ddram[ddram_index(dbg_addr)];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= 8'h00;
        end else begin
            rd_data <= rs_sync[1] ? ac_byte : {bf, ac};
        end
    end

    assign LCD_data = (LCD_E & LCD_RW) ? rd_data : 8'hzz;

endmodule
`default_nettype wire

// File: tb/tb_lcd_hd44780_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lcd_hd44780_responder                                                 |
// | Randomized bus-cycle bench with a behavioural LCD model.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_lcd_hd44780_responder;

    localparam int EXEC_CYCLES  = 24;
    localparam int CLEAR_CYCLES = 150;
    localparam int BUSY_W       = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    wire  [7:0] LCD_data;
    logic       host_oe;
    logic [7:0] host_data;
    logic [6:0] dbg_addr;
    logic [7:0] dbg_char;
    logic       disp_on;
    logic       cursor_on;
    logic       blink_on;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;

    assign LCD_data = host_oe ? host_data : 8'hzz;

    lcd_hd44780_responder #(
        .EXEC_CYCLES (EXEC_CYCLES),
        .CLEAR_CYCLES(CLEAR_CYCLES),
        .BUSY_W      (BUSY_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .LCD_E    (LCD_E),
        .LCD_RS   (LCD_RS),
        .LCD_RW   (LCD_RW),
        .LCD_data (LCD_data),
        .dbg_addr (dbg_addr),
        .dbg_char (dbg_char),
        .disp_on  (disp_on),
        .cursor_on(cursor_on),
        .blink_on (blink_on),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Behavioural model: DDRAM as 80 linear cells, visible addresses mapped from line/col.
    logic [7:0] m_dd [80];
    bit         m_dd_known [80];
    logic [7:0] m_cg [64];
    bit         m_cg_known [64];
    int         m_ac;
    bit         m_cg_t, m_inc, m_d, m_c, m_b, m_err;

    function automatic bit m_valid(input int a);
        return (a >= 0 && a < 40) || (a >= 64 && a < 104);
    endfunction

    function automatic int m_pos(input int a);
        return (a >= 64) ? 40 + (a - 64) : a;
    endfunction

    function automatic int m_addr(input int p);
        return (p / 40) * 64 + (p % 40);
    endfunction

    function automatic int m_step(input int a, input bit cg, input bit up);
        if (cg) return up ? (a + 1) % 64 : (a + 63) % 64;
        if (m_valid(a)) return m_addr(up ? (m_pos(a) + 1) % 80 : (m_pos(a) + 79) % 80);
        return up ? (a + 1) % 128 : (a + 127) % 128;
    endfunction

    task automatic model_reset();
        m_ac = 0; m_cg_t = 0; m_inc = 1; m_d = 0; m_c = 0; m_b = 0; m_err = 0;
    endtask

    task automatic model_inst(input logic [7:0] v);
        if (v == 8'h01) begin
            for (int p = 0; p < 80; p++) begin
                m_dd[p] = 8'h20; m_dd_known[p] = 1;
            end
            m_ac = 0; m_inc = 1;
        end else if (v < 8'h04) m_ac = 0;
        else if (v < 8'h08) m_inc = v[1];
        else if (v < 8'h10) begin m_d = v[2]; m_c = v[1]; m_b = v[0]; end
        else if (v < 8'h20) begin
            if (!v[3]) m_ac = m_step(m_ac, m_cg_t, v[2]);
        end
        else if (v < 8'h40) begin end
        else if (v < 8'h80) begin m_ac = int'(v) % 64; m_cg_t = 1; end
        else begin m_ac = int'(v) % 128; m_cg_t = 0; end
    endtask

    task automatic model_data_write(input logic [7:0] v);
        if (m_cg_t) begin
            m_cg[m_ac] = v; m_cg_known[m_ac] = 1;
        end else if (m_valid(m_ac)) begin
            m_dd[m_pos(m_ac)] = v; m_dd_known[m_pos(m_ac)] = 1;
        end
        m_ac = m_step(m_ac, m_cg_t, m_inc);
    endtask

    task automatic model_data_read(output logic [7:0] v, output bit known);
        if (m_cg_t) begin v = m_cg[m_ac]; known = m_cg_known[m_ac]; end
        else if (m_valid(m_ac)) begin v = m_dd[m_pos(m_ac)]; known = m_dd_known[m_pos(m_ac)]; end
        else begin v = 8'h20; known = 1; end
        m_ac = m_step(m_ac, m_cg_t, m_inc);
    endtask

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic lcd_write(input logic rs, input logic [7:0] v);
        @(negedge clk);
        LCD_RS = rs; LCD_RW = 1'b0; host_data = v; host_oe = 1'b1;
        repeat (2) @(negedge clk);
        LCD_E = 1'b1;
        repeat (4) @(negedge clk);
        LCD_E = 1'b0;
        repeat (4) @(negedge clk);
        host_oe = 1'b0;
    endtask

    task automatic lcd_read(input logic rs, output logic [7:0] v);
        @(negedge clk);
        host_oe = 1'b0; LCD_RS = rs; LCD_RW = 1'b1;
        repeat (2) @(negedge clk);
        LCD_E = 1'b1;
        repeat (5) @(negedge clk);
        v = LCD_data;
        LCD_E = 1'b0;
        repeat (4) @(negedge clk);
        LCD_RW = 1'b0;
    endtask

    // Polls status until BF clears (bounded), then compares the whole status byte.
    task automatic settle_and_check(input string tag);
        logic [7:0] s;
        int polls;
        polls = 0;
        lcd_read(1'b0, s);
        while (s[7] && polls < 100) begin
            lcd_read(1'b0, s);
            polls++;
        end
        check_value(tag, s, m_ac % 128);
    endtask

    task automatic do_inst(input logic [7:0] v);
        lcd_write(1'b0, v);
        model_inst(v);
        settle_and_check("status_after_inst");
    endtask

    task automatic do_data(input logic [7:0] v);
        lcd_write(1'b1, v);
        model_data_write(v);
        settle_and_check("status_after_data");
    endtask

    task automatic check_dbg(input int a);
        dbg_addr = 7'(a);
        #1;
        if (!m_valid(a)) check_value("dbg_invalid", dbg_char, 8'h20);
        else if (m_dd_known[m_pos(a)]) check_value("dbg_char", dbg_char, m_dd[m_pos(a)]);
    endtask

    task automatic check_ctrl();
        check_value("disp_cursor_blink", {disp_on, cursor_on, blink_on}, {m_d, m_c, m_b});
        check_value("err_flag", err, m_err);
    endtask

    // Issues an instruction, then holds a status read open and counts clocks
    // from the E fall until BF drops on the bus (3 clk to update + 1 clk read register).
    task automatic measure_busy(input logic [7:0] v, output int len);
        @(negedge clk);
        LCD_RS = 1'b0; LCD_RW = 1'b0; host_data = v; host_oe = 1'b1;
        repeat (2) @(negedge clk);
        LCD_E = 1'b1;
        repeat (4) @(negedge clk);
        LCD_E = 1'b0; host_oe = 1'b0; LCD_RW = 1'b1;
        repeat (4) @(negedge clk);
        LCD_E = 1'b1;
        #1;
        len = 4;
        while (LCD_data[7] === 1'b1 && len < CLEAR_CYCLES + 100) begin
            @(negedge clk);
            len++;
        end
        LCD_E = 1'b0;
        repeat (4) @(negedge clk);
        LCD_RW = 1'b0;
        model_inst(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rv, ev;
        bit         known;
        int         len, polls, op, a;

        LCD_E = 0; LCD_RS = 0; LCD_RW = 0; host_oe = 0; host_data = 8'h00; dbg_addr = 7'h00;
        for (int p = 0; p < 80; p++) m_dd_known[p] = 0;
        for (int p = 0; p < 64; p++) m_cg_known[p] = 0;
        model_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        check_ctrl();
        lcd_read(1'b0, rv);
        check_value("reset_status", rv, 8'h00);
        check_dbg(7'h30);
        check_dbg(7'h68);

        do_inst(8'h38);
        measure_busy(8'h0F, len);
        check_value("exec_busy_len", len, EXEC_CYCLES + 4);
        do_inst(8'h06);
        measure_busy(8'h01, len);
        check_value("clear_busy_len", len, CLEAR_CYCLES + 4);
        settle_and_check("status_after_clear");
        do_data(8'h48);
        do_data(8'h69);
        check_dbg(7'h00);
        check_dbg(7'h01);
        check_ctrl();

        do_inst(8'hA7);
        do_data(8'h41);
        do_data(8'h42);
        check_dbg(7'h27);
        check_dbg(7'h40);
        do_inst(8'h04);
        do_inst(8'h80);
        do_data(8'h43);
        check_dbg(7'h00);
        do_inst(8'h06);

        // Clear, then a data write landing early in the busy window must be dropped.
        lcd_write(1'b0, 8'h01);
        model_inst(8'h01);
        lcd_write(1'b1, 8'h55);
        m_err = 1;
        settle_and_check("status_after_dropped_write");
        check_ctrl();
        for (int p = 0; p < 80; p++) check_dbg(m_addr(p));

        do_inst(8'h40);
        do_data(8'h1F);
        do_inst(8'h40);
        lcd_read(1'b1, rv);
        model_data_read(ev, known);
        check_value("cgram_read", rv, ev);
        settle_and_check("status_after_cgram_read");

        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 10);
            case (op)
                0, 1: do_data(8'($urandom_range(0, 255)));
                2, 3: begin
                    lcd_read(1'b1, rv);
                    model_data_read(ev, known);
                    if (known) check_value("rand_data_read", rv, ev);
                    settle_and_check("status_after_read");
                end
                4, 5: do_inst(8'h80 | 8'($urandom_range(0, 127)));
                6: do_inst(8'h40 | 8'($urandom_range(0, 63)));
                7: do_inst(8'h04 | 8'($urandom_range(0, 3)));
                8: do_inst(8'h08 | 8'($urandom_range(0, 7)));
                9: do_inst(8'h10 | 8'($urandom_range(0, 15)));
                default: do_inst(($urandom_range(0, 3) == 0) ? 8'h02 : (8'h20 | 8'($urandom_range(0, 31))));
            endcase
            a = $urandom_range(0, 127);
            check_dbg(a);
            check_ctrl();
        end

        // Reset in the middle of a clear fill.
        do_inst(8'h06);
        do_inst(8'h80);
        for (int p = 0; p < 80; p++) do_data(8'(p) ^ 8'hA5);
        dbg_addr = 7'h27;
        lcd_write(1'b0, 8'h01);
        polls = 0;
        while (dbg_char !== 8'h20 && polls < 300) begin
            @(negedge clk);
            polls++;
        end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int p = 0; p < 40; p++) m_dd[p] = 8'h20;
        model_reset();
        check_ctrl();
        settle_and_check("status_after_midclear_reset");
        for (int p = 0; p < 80; p++) check_dbg(m_addr(p));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
